instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0, byte address loaded into the PC on reset; bits [1:0] SHALL be zero.
REQ-002 Parameter: ADDR_W, 64, PC and memory address width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: imem_req  output  1  instruction-memory read request.
REQ-006 Port: imem_addr  output  ADDR_W  read address; equals current PC.
REQ-007 Port: imem_ack  input  1  memory returns data this cycle; ignored unless imem_req=1.
REQ-008 Port: imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 Port: instr_valid  output  1  held instruction available to decode/control unit.
REQ-010 Port: instr_ready  input  1  downstream consumes held instruction this cycle.
REQ-011 Port: instr  output  32  held instruction word.
REQ-012 Port: opcode  output  7  instr[6:0]; drives control unit opcode input.
REQ-013 Port: instr_pc  output  ADDR_W  address the held instruction was fetched from.
REQ-014 Port: branch_taken  input  1  redirect request from execute stage.
REQ-015 Port: branch_target  input  ADDR_W  redirect address.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD; all outputs registered or decoded from state only (no input-to-output combinational path).
REQ-017 IDLE: imem_req=0, instr_valid=0; unconditional transition to FETCH next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=pc; stays in FETCH until imem_ack=1 (no timeout).
REQ-019 FETCH with imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, next state HOLD.
REQ-020 HOLD: imem_req=0, instr_valid=1, instr/instr_pc stable; with instr_ready=1 -> instr_valid<=0, next state FETCH; else remain.
REQ-021 Steady-state throughput: one instruction per 2 cycles plus memory wait cycles.
REQ-022 PC increment SHALL be modulo 2^ADDR_W (all-ones-minus-3 + 4 wraps to 0).
REQ-023 branch_taken=1 in any state (reset excepted) SHALL take priority: pc<={branch_target[ADDR_W-1:2],2'b00}, instr_valid<=0, next state FETCH.
REQ-024 Simultaneous branch_taken and imem_ack: returned data SHALL be discarded; instr/instr_pc unchanged; fetch restarts at target next cycle.
REQ-025 Simultaneous branch_taken and instr_ready in HOLD: held instruction counts as consumed; redirect applies.
REQ-026 branch_target bits [1:0] SHALL be ignored (forced zero), no error signalled.
REQ-027 opcode SHALL always equal instr[6:0], including when instr_valid=0.

Reset
REQ-028 rst=1 at rising edge: pc<=RESET_PC, state<=IDLE, instr_valid<=0, instr<=32'h0, instr_pc<=0; imem_req=0 the following cycle.
REQ-029 rst SHALL override branch_taken, imem_ack and instr_ready; reset mid-fetch discards any in-flight response.
REQ-030 First request after reset release SHALL appear 1 cycle after the IDLE cycle, at imem_addr=RESET_PC.

Verification
REQ-031 Reset, release, imem_ack=1 every FETCH cycle, imem_rdata=32'h00003003 (LOAD) -> imem_addr 0x0 then 0x4; opcode=7'b0000011, instr_pc=0x0 when instr_valid=1.
REQ-032 imem_ack held low 3 cycles in FETCH -> imem_req stays 1, imem_addr stable, instr_valid stays 0; ack on 4th cycle -> instr_valid=1 next cycle.
REQ-033 instr_ready=0 for 5 cycles in HOLD -> instr, opcode, instr_pc unchanged, imem_req=0; instr_ready=1 -> instr_valid=0, next imem_addr=instr_pc+4.
REQ-034 branch_taken=1, branch_target=0x1003, same cycle as imem_ack -> data discarded, instr_valid=0, next imem_addr=0x1000.
REQ-035 pc=64'hFFFF_FFFF_FFFF_FFFC, ack -> next imem_addr=0x0.
REQ-036 rst asserted during FETCH with ack pending -> instr_valid=0, imem_req=0 next cycle, restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the PC through instruction memory with a
// simple request/acknowledge handshake and holds each fetched word until
// the decode stage consumes it. Branch redirects from execute override the
// sequential flow in every state.
module instr_fetch #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [6:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target_aligned;
  logic              fetch_done;

  // Low target bits are dropped silently; instructions are word aligned.
  logic [1:0] unused_target_lsb;
  assign unused_target_lsb = branch_target[1:0];
  assign target_aligned    = {branch_target[ADDR_W-1:2], 2'b00};

  // A response is only captured when no redirect arrives in the same cycle.
  assign fetch_done = (state == FETCH) && imem_ack && !branch_taken;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a redirect always restarts fetching at the target
  always_comb begin
    state_next = state;
    if (branch_taken) begin
      state_next = FETCH;
    end else begin
      case (state)
        IDLE:    state_next = FETCH;
        FETCH:   state_next = imem_ack ? HOLD : FETCH;
        HOLD:    state_next = instr_ready ? FETCH : HOLD;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs decoded from state and registers only, no input feed-through
  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == HOLD);
    imem_addr   = pc;
    opcode      = instr[6:0];
  end

  // Program counter: redirect wins over sequential advance, wraps modulo 2^ADDR_W
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= target_aligned;
    end else if (fetch_done) begin
      pc <= pc + ADDR_W'(4);
    end
  end

  // Held instruction and its fetch address, loaded on an accepted response
  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= 32'h0;
      instr_pc <= '0;
    end else if (fetch_done) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: reset, sequential fetch, memory wait
// states, hold back-pressure, branch collisions, PC wrap and mid-fetch reset.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [63:0] instr_pc;
  logic        branch_taken;
  logic [63:0] branch_target;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .opcode       (opcode),
    .instr_pc     (instr_pc),
    .branch_taken (branch_taken),
    .branch_target(branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 64'h500;
    step(); step();
    rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instr); end
    n_checks++; if (instr_pc !== 64'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    n_checks++; if (opcode !== 7'h0) begin n_fail++; $display("FAIL reset_opcode: got %h expected 0", opcode); end
    // IDLE cycle ends, first request at RESET_PC
    step();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", imem_req); end
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL first_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_load();
    imem_ack = 1'b1; imem_rdata = 32'h0000_3003;
    step();
    imem_ack = 1'b0;
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b expected 1", instr_valid); end
    n_checks++; if (opcode !== 7'b0000011) begin n_fail++; $display("FAIL load_opcode: got %b expected 0000011", opcode); end
    n_checks++; if (instr !== 32'h0000_3003) begin n_fail++; $display("FAIL load_instr: got %h expected 00003003", instr); end
    n_checks++; if (instr_pc !== 64'h0) begin n_fail++; $display("FAIL load_instr_pc: got %h expected 0", instr_pc); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL load_hold_req: got %b expected 0", imem_req); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL load_consumed: got %b expected 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL load_req2: got %b expected 1", imem_req); end
    n_checks++; if (imem_addr !== 64'h4) begin n_fail++; $display("FAIL load_addr2: got %h expected 4", imem_addr); end
  endtask

  task automatic test_wait();
    imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req[%0d]: got %b expected 1", i, imem_req); end
      n_checks++; if (imem_addr !== 64'h4) begin n_fail++; $display("FAIL wait_addr[%0d]: got %h expected 4", i, imem_addr); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid[%0d]: got %b expected 0", i, instr_valid); end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_valid_after_ack: got %b expected 1", instr_valid); end
    n_checks++; if (instr_pc !== 64'h4) begin n_fail++; $display("FAIL wait_instr_pc: got %h expected 4", instr_pc); end
    n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL wait_instr: got %h expected 00000013", instr); end
  endtask

  task automatic test_hold();
    instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FF7F;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL hold_instr[%0d]: got %h expected 00000013", i, instr); end
      n_checks++; if (opcode !== 7'h13) begin n_fail++; $display("FAIL hold_opcode[%0d]: got %h expected 13", i, opcode); end
      n_checks++; if (instr_pc !== 64'h4) begin n_fail++; $display("FAIL hold_instr_pc[%0d]: got %h expected 4", i, instr_pc); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got %b expected 0", i, imem_req); end
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, instr_valid); end
    end
    imem_ack = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b expected 0", instr_valid); end
    n_checks++; if (imem_addr !== 64'h8) begin n_fail++; $display("FAIL hold_release_addr: got %h expected 8", imem_addr); end
  endtask

  task automatic test_branch_ack();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    branch_taken = 1'b1; branch_target = 64'h1003;
    step();
    imem_ack = 1'b0; branch_taken = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL bra_ack_valid: got %b expected 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL bra_ack_req: got %b expected 1", imem_req); end
    n_checks++; if (imem_addr !== 64'h1000) begin n_fail++; $display("FAIL bra_ack_addr: got %h expected 1000", imem_addr); end
    n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL bra_ack_instr: got %h expected 00000013", instr); end
    n_checks++; if (instr_pc !== 64'h4) begin n_fail++; $display("FAIL bra_ack_instr_pc: got %h expected 4", instr_pc); end
  endtask

  task automatic test_branch_ready();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0063;
    step();
    imem_ack = 1'b0;
    n_checks++; if (instr_pc !== 64'h1000) begin n_fail++; $display("FAIL bra_rdy_instr_pc: got %h expected 1000", instr_pc); end
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 64'h2000;
    step();
    instr_ready = 1'b0; branch_taken = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL bra_rdy_valid: got %b expected 0", instr_valid); end
    n_checks++; if (imem_addr !== 64'h2000) begin n_fail++; $display("FAIL bra_rdy_addr: got %h expected 2000", imem_addr); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL bra_rdy_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_align: got %h expected fffffffffffffffc", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0037;
    step();
    imem_ack = 1'b0;
    n_checks++; if (instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_instr_pc: got %h expected fffffffffffffffc", instr_pc); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 0", imem_addr); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_reset_mid_fetch();
    branch_taken = 1'b1; branch_target = 64'h3000;
    step();
    branch_taken = 1'b0;
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_006F;
    step();
    rst = 1'b0; imem_ack = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b expected 0", imem_req); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rstmid_instr: got %h expected 0", instr); end
    step();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart_req: got %b expected 1", imem_req); end
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL rstmid_restart_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_back_to_back();
    // One instruction every two cycles with zero-wait memory
    imem_ack = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'h0000_0100 + 32'(i);
      step();
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, instr_valid); end
      n_checks++; if (instr_pc !== 64'(4 * i)) begin n_fail++; $display("FAIL b2b_instr_pc[%0d]: got %h expected %h", i, instr_pc, 64'(4 * i)); end
      n_checks++; if (instr !== 32'h0000_0100 + 32'(i)) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, instr, 32'h100 + 32'(i)); end
      step();
      n_checks++; if (imem_addr !== 64'(4 * (i + 1))) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, imem_addr, 64'(4 * (i + 1))); end
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 64'h0;
    #1;
    test_reset();
    test_load();
    test_wait();
    test_hold();
    test_branch_ack();
    test_branch_ready();
    test_wrap();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
